// File: rtl/writeback_unit_if.sv
// Result handshake bundle between the ALU and the writeback unit.
// master: ALU side drives valid/op/rdst/result; slave: writeback drives ready.
interface writeback_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [5:0]            in_op;
  logic [ADDR_W-1:0]     in_rdst1;
  logic [ADDR_W-1:0]     in_rdst2;
  logic [2*DATA_W-1:0]   in_result;

  modport master (
    output in_valid,
    output in_op,
    output in_rdst1,
    output in_rdst2,
    output in_result,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_rdst1,
    input  in_rdst2,
    input  in_result,
    output in_ready
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: holds one ALU result, writes it into the register file
// (two writes for MUL), exposes two bypassed read ports and a retire count.
// Ports: clk, reset (async high), wb (result handshake, slave),
//   rd_addr_a/b -> rd_data_a/b, wr_en_o/wr_addr_o/wr_data_o, retire_count.
module writeback_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  writeback_unit_if.slave   wb,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [15:0]       retire_count
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WR_LO = 2'd1;
  localparam logic [1:0] S_WR_HI = 2'd2;

  localparam logic [5:0] OP_MUL = 6'b000111;

  logic [1:0]          r_state;
  logic [5:0]          r_op;
  logic [ADDR_W-1:0]   r_rdst1;
  logic [ADDR_W-1:0]   r_rdst2;
  logic [2*DATA_W-1:0] r_result;
  logic [DATA_W-1:0]   r_regs [DEPTH];
  logic [15:0]         r_retire;

  logic [1:0]          w_state_nxt;
  logic                w_is_mul;
  logic                w_op_wr;
  logic                w_xfer;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;
  logic                w_retire;

  assign w_is_mul = (r_op == OP_MUL);

  assign w_op_wr = (r_op == 6'd0) ||
                   (r_op == 6'd1) ||
                   ((r_op >= 6'd4) && (r_op <= 6'd16));

  // Only the MUL low-half cycle blocks: its high half needs the next slot.
  assign wb.in_ready = !((r_state == S_WR_LO) && w_is_mul);

  assign w_xfer = wb.in_valid && wb.in_ready;

  always_comb begin
    w_state_nxt = S_IDLE;
    unique case (1'b1)
      w_xfer:
        w_state_nxt = S_WR_LO;
      (r_state == S_WR_LO) && w_is_mul:
        w_state_nxt = S_WR_HI;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  assign w_wr_en = ((r_state == S_WR_LO) && w_op_wr) ||
                   (r_state == S_WR_HI);

  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    if (w_wr_en) begin
      if (r_state == S_WR_HI) begin
        w_wr_addr = r_rdst2;
        w_wr_data = r_result[2*DATA_W-1:DATA_W];
      end else begin
        w_wr_addr = r_rdst1;
        w_wr_data = r_result[DATA_W-1:0];
      end
    end
  end

  // Non-writing ops still retire; MUL retires only after its high half.
  assign w_retire = ((r_state == S_WR_LO) && !w_is_mul) ||
                    (r_state == S_WR_HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_rdst1  <= '0;
      r_rdst2  <= '0;
      r_result <= '0;
      r_retire <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_op     <= wb.in_op;
        r_rdst1  <= wb.in_rdst1;
        r_rdst2  <= wb.in_rdst2;
        r_result <= wb.in_result;
      end
      if (w_wr_en) begin
        r_regs[w_wr_addr] <= w_wr_data;
      end
      if (w_retire) begin
        r_retire <= r_retire + 16'd1;
      end
    end
  end

  // Write-first: a read of the register being written sees the new value.
  assign rd_data_a = (w_wr_en && (rd_addr_a == w_wr_addr)) ?
                     w_wr_data : r_regs[rd_addr_a];
  assign rd_data_b = (w_wr_en && (rd_addr_b == w_wr_addr)) ?
                     w_wr_data : r_regs[rd_addr_b];

  assign wr_en_o      = w_wr_en;
  assign wr_addr_o    = w_wr_addr;
  assign wr_data_o    = w_wr_data;
  assign retire_count = r_retire;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: scoreboard of expected register writes plus a
// register/retire model, with one task per scenario.
module tb_writeback_unit;

  logic        clk;
  logic        reset;
  logic [5:0]  rd_addr_a;
  logic [5:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        wr_en_o;
  logic [5:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic [15:0] retire_count;

  writeback_unit_if #(.DATA_W(16), .ADDR_W(6)) wbif ();

  writeback_unit #(.DATA_W(16), .ADDR_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb           (wbif.slave),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .retire_count (retire_count)
  );

  typedef struct {
    logic [5:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         sb[$];
  logic [15:0] mdl_regs [64];
  logic [15:0] mdl_retire;
  int          n_tests;
  int          n_fail;

  localparam logic [5:0] OP_ADD = 6'b000100;
  localparam logic [5:0] OP_OR  = 6'b000101;
  localparam logic [5:0] OP_MUL = 6'b000111;
  localparam logic [5:0] OP_ST  = 6'b000011;
  localparam logic [5:0] OP_NOP = 6'b111111;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_wr(input logic [5:0] op);
    return (op == 6'd0) || (op == 6'd1) ||
           ((op >= 6'd4) && (op <= 6'd16));
  endfunction

  // Monitor: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && wr_en_o) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected addr=%0d data=%h", wr_addr_o,
                 wr_data_o);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (wr_addr_o !== e.a || wr_data_o !== e.d) begin
          n_fail++;
          $display("FAIL sb_write got %0d/%h want %0d/%h",
                   wr_addr_o, wr_data_o, e.a, e.d);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Offer one result; returns 1 time unit after the accepting edge with
  // in_valid still high so callers can chain back-to-back transfers.
  task automatic put(input logic [5:0] op, input logic [5:0] r1,
                     input logic [5:0] r2, input logic [31:0] res);
    int w;
    w = 0;
    wbif.in_valid  = 1'b1;
    wbif.in_op     = op;
    wbif.in_rdst1  = r1;
    wbif.in_rdst2  = r2;
    wbif.in_result = res;
    while (!wbif.in_ready && w < 8) begin
      sync();
      w++;
    end
    if (!wbif.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL put_timeout ready=%b want 1", wbif.in_ready);
      wbif.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (is_wr(op)) begin
        sb.push_back('{a: r1, d: res[15:0]});
        mdl_regs[r1] = res[15:0];
      end
      if (op == OP_MUL) begin
        sb.push_back('{a: r2, d: res[31:16]});
        mdl_regs[r2] = res[31:16];
      end
      mdl_retire = mdl_retire + 16'd1;
      #1;
    end
  endtask

  task automatic drain();
    wbif.in_valid = 1'b0;
    repeat (3) sync();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_sb pending=%0d want 0", sb.size());
      sb.delete();
    end
    n_tests++;
    if (retire_count !== mdl_retire) begin
      n_fail++;
      $display("FAIL retire got %0d want %0d", retire_count, mdl_retire);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mdl_retire = '0;
    for (int i = 0; i < 64; i++) mdl_regs[i] = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_tests++;
    if (wbif.in_ready !== 1'b1 || wr_en_o !== 1'b0 ||
        wr_addr_o !== 6'd0 || wr_data_o !== 16'd0 ||
        retire_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outs rdy=%b en=%b a=%0d d=%h rc=%0d want 1 0 0 0 0",
               wbif.in_ready, wr_en_o, wr_addr_o, wr_data_o, retire_count);
    end
    for (int i = 0; i < 64; i++) begin
      rd_addr_a = i[5:0];
      #1;
      n_tests++;
      if (rd_data_a !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_reg r%0d got %h want 0", i, rd_data_a);
      end
    end
    sync();
    reset = 1'b0;
    sync();
  endtask

  task automatic test_add();
    put(OP_ADD, 6'd5, 6'd0, 32'h0000_1234);
    wbif.in_valid = 1'b0;
    n_tests++;
    if (wr_en_o !== 1'b1 || wr_addr_o !== 6'd5 ||
        wr_data_o !== 16'h1234) begin
      n_fail++;
      $display("FAIL add_write got %b/%0d/%h want 1/5/1234",
               wr_en_o, wr_addr_o, wr_data_o);
    end
    drain();
    rd_addr_a = 6'd5;
    #1;
    n_tests++;
    if (rd_data_a !== mdl_regs[5] || rd_data_a !== 16'h1234) begin
      n_fail++;
      $display("FAIL add_r5 got %h want 1234", rd_data_a);
    end
    n_tests++;
    if (retire_count !== 16'd1) begin
      n_fail++;
      $display("FAIL add_retire got %0d want 1", retire_count);
    end
    sync();
  endtask

  task automatic test_mul();
    put(OP_MUL, 6'd3, 6'd4, 32'hABCD_1357);
    wbif.in_valid = 1'b0;
    n_tests++;
    if (wbif.in_ready !== 1'b0 || wr_addr_o !== 6'd3 ||
        wr_data_o !== 16'h1357) begin
      n_fail++;
      $display("FAIL mul_lo rdy=%b a=%0d d=%h want 0/3/1357",
               wbif.in_ready, wr_addr_o, wr_data_o);
    end
    sync();
    n_tests++;
    if (wbif.in_ready !== 1'b1 || wr_en_o !== 1'b1 ||
        wr_addr_o !== 6'd4 || wr_data_o !== 16'hABCD) begin
      n_fail++;
      $display("FAIL mul_hi rdy=%b en=%b a=%0d d=%h want 1/1/4/abcd",
               wbif.in_ready, wr_en_o, wr_addr_o, wr_data_o);
    end
    drain();
    rd_addr_a = 6'd3;
    rd_addr_b = 6'd4;
    #1;
    n_tests++;
    if (rd_data_a !== 16'h1357 || rd_data_b !== 16'hABCD) begin
      n_fail++;
      $display("FAIL mul_regs got %h/%h want 1357/abcd",
               rd_data_a, rd_data_b);
    end
    sync();
    put(OP_MUL, 6'd3, 6'd3, 32'hABCD_1357);
    drain();
    rd_addr_a = 6'd3;
    #1;
    n_tests++;
    if (rd_data_a !== mdl_regs[3] || rd_data_a !== 16'hABCD) begin
      n_fail++;
      $display("FAIL mul_same got %h want abcd", rd_data_a);
    end
    sync();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      put(OP_OR, i[5:0], 6'd0, 32'(i));
      n_tests++;
      if (wbif.in_ready !== 1'b1 || wr_en_o !== 1'b1 ||
          wr_addr_o !== i[5:0]) begin
        n_fail++;
        $display("FAIL b2b_%0d rdy=%b en=%b a=%0d want 1/1/%0d",
                 i, wbif.in_ready, wr_en_o, wr_addr_o, i);
      end
    end
    drain();
    for (int i = 1; i <= 3; i++) begin
      rd_addr_b = i[5:0];
      #1;
      n_tests++;
      if (rd_data_b !== 16'(i)) begin
        n_fail++;
        $display("FAIL b2b_reg r%0d got %h want %h", i, rd_data_b, 16'(i));
      end
    end
    sync();
  endtask

  task automatic test_nonwriting();
    logic [15:0] r0;
    r0 = mdl_retire;
    put(OP_ST, 6'd5, 6'd6, 32'hDEAD_BEEF);
    n_tests++;
    if (wr_en_o !== 1'b0 || wr_addr_o !== 6'd0 || wr_data_o !== 16'd0) begin
      n_fail++;
      $display("FAIL store_wen en=%b a=%0d d=%h want 0/0/0",
               wr_en_o, wr_addr_o, wr_data_o);
    end
    put(OP_NOP, 6'd5, 6'd6, 32'hCAFE_F00D);
    wbif.in_valid = 1'b0;
    n_tests++;
    if (wr_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL op3f_wen got %b want 0", wr_en_o);
    end
    drain();
    n_tests++;
    if (retire_count !== r0 + 16'd2) begin
      n_fail++;
      $display("FAIL nonwr_retire got %0d want %0d", retire_count,
               r0 + 16'd2);
    end
    rd_addr_a = 6'd5;
    #1;
    n_tests++;
    if (rd_data_a !== mdl_regs[5]) begin
      n_fail++;
      $display("FAIL nonwr_r5 got %h want %h", rd_data_a, mdl_regs[5]);
    end
    sync();
  endtask

  task automatic test_bypass();
    put(OP_ADD, 6'd7, 6'd0, 32'h0000_1111);
    drain();
    put(OP_ADD, 6'd7, 6'd0, 32'h0000_00FF);
    wbif.in_valid = 1'b0;
    rd_addr_a = 6'd7;
    rd_addr_b = 6'd5;
    #1;
    n_tests++;
    if (rd_data_a !== 16'h00FF) begin
      n_fail++;
      $display("FAIL bypass_a got %h want 00ff", rd_data_a);
    end
    n_tests++;
    if (rd_data_b !== mdl_regs[5]) begin
      n_fail++;
      $display("FAIL bypass_b got %h want %h", rd_data_b, mdl_regs[5]);
    end
    drain();
  endtask

  task automatic test_reset_midop();
    put(OP_MUL, 6'd10, 6'd11, 32'h5555_AAAA);
    wbif.in_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (wr_en_o !== 1'b0 || retire_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midop_async en=%b rc=%0d want 0/0",
               wr_en_o, retire_count);
    end
    repeat (2) sync();
    reset = 1'b0;
    n_tests++;
    if (wbif.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_ready got %b want 1", wbif.in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      sync();
      n_tests++;
      if (wr_en_o !== 1'b0) begin
        n_fail++;
        $display("FAIL midop_nowrite c%0d got %b want 0", c, wr_en_o);
      end
    end
    for (int i = 0; i < 64; i++) begin
      rd_addr_a = i[5:0];
      #1;
      n_tests++;
      if (rd_data_a !== 16'd0) begin
        n_fail++;
        $display("FAIL midop_reg r%0d got %h want 0", i, rd_data_a);
      end
    end
    n_tests++;
    if (retire_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midop_retire got %0d want 0", retire_count);
    end
    sync();
    reset = 1'b1;
    sync();
    reset = 1'b0;
    put(OP_ADD, 6'd9, 6'd0, 32'h0000_0042);
    wbif.in_valid = 1'b0;
    n_tests++;
    if (wr_en_o !== 1'b1 || wr_addr_o !== 6'd9 ||
        wr_data_o !== 16'h0042) begin
      n_fail++;
      $display("FAIL first_xfer got %b/%0d/%h want 1/9/0042",
               wr_en_o, wr_addr_o, wr_data_o);
    end
    drain();
  endtask

  task automatic test_wrap();
    int n;
    n = 32'hFFFF - int'(mdl_retire);
    for (int i = 0; i < n; i++) begin
      put(OP_NOP, 6'd0, 6'd0, 32'(i));
    end
    drain();
    n_tests++;
    if (retire_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_max got %h want ffff", retire_count);
    end
    put(OP_NOP, 6'd0, 6'd0, 32'd0);
    drain();
    n_tests++;
    if (retire_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_zero got %h want 0000", retire_count);
    end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset          = 1'b1;
    rd_addr_a      = '0;
    rd_addr_b      = '0;
    wbif.in_valid  = 1'b0;
    wbif.in_op     = '0;
    wbif.in_rdst1  = '0;
    wbif.in_rdst2  = '0;
    wbif.in_result = '0;
    model_reset();
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_nonwriting();
    test_bypass();
    test_reset_midop();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DATA_W, default 16: register width in bits.
REQ-002 Parameter ADDR_W, default 6: register address width; register file depth is 2**ADDR_W (64).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  ALU result is valid this cycle.
REQ-006 in_ready  output  1  unit accepts a result this cycle.
REQ-007 in_op  input  6  opcode (instruction bits [31:26]) of the result.
REQ-008 in_rdst1  input  6  destination register for the low half.
REQ-009 in_rdst2  input  6  destination register for the high half (MUL only).
REQ-010 in_result  input  32  ALU result; [15:0] is the low half, [31:16] is the high half.
REQ-011 rd_addr_a, rd_addr_b  input  6 each  operand read addresses.
REQ-012 rd_data_a, rd_data_b  output  16 each  operand read data.
REQ-013 wr_en_o  output  1  register write strobe (observation).
REQ-014 wr_addr_o  output  6  register write address (observation).
REQ-015 wr_data_o  output  16  register write data (observation).
REQ-016 retire_count  output  16  number of accepted results whose writeback has completed.

Function
REQ-017 Storage: 64 x 16-bit register array, written only by this unit.
REQ-018 FSM states: IDLE, WR_LO, WR_HI.
REQ-019 Handshake: a transfer occurs on a rising edge where in_valid=1 and in_ready=1; in_op, in_rdst1, in_rdst2 and in_result are captured into holding registers on that edge.
REQ-020 in_ready = 0 only in WR_LO when the held op is MUL (6'b000111); in_ready = 1 in every other state.
REQ-021 Transitions: any state with a transfer -> WR_LO; WR_LO with held op MUL -> WR_HI; WR_LO with held op not MUL and no transfer -> IDLE; WR_HI with no transfer -> IDLE.
REQ-022 Writing opcodes: 000000, 000001, and 000100 through 010000 inclusive.
REQ-023 WR_LO with a writing opcode: wr_en_o=1, wr_addr_o=held rdst1, wr_data_o=held result[15:0]; the array entry updates at the end of the cycle.
REQ-024 WR_HI: wr_en_o=1, wr_addr_o=held rdst2, wr_data_o=held result[31:16].
REQ-025 Non-writing opcodes (000010, 000011, 000101..? no -- 000010, 000011, and 010001..111111): the result is accepted, WR_LO is spent with wr_en_o=0, and no register changes.
REQ-026 Latency: a non-MUL result is written in the cycle after acceptance; a MUL low half is written 1 cycle after acceptance and the high half 2 cycles after acceptance.
REQ-027 Throughput: back-to-back non-MUL results sustain one per cycle; each MUL costs 2 cycles.
REQ-028 wr_en_o=0 in IDLE; wr_addr_o and wr_data_o are 0 whenever wr_en_o=0.
REQ-029 Read ports are combinational from the array, with write-first bypass: if wr_en_o=1 and rd_addr==wr_addr_o, rd_data=wr_data_o.
REQ-030 MUL with in_rdst1==in_rdst2: the high-half write is applied last, so the register holds result[31:16].
REQ-031 retire_count increments by 1 at the end of WR_LO for non-MUL ops, including non-writing ops, and at the end of WR_HI for MUL; it wraps from 0xFFFF to 0x0000.

Reset
REQ-032 reset=1 asynchronously forces: state IDLE, all 64 registers to 0, holding registers to 0, retire_count to 0, wr_en_o=0, and in_ready=1.
REQ-033 Reset asserted mid-operation (WR_LO or WR_HI) abandons the pending write; no partial MUL high-half write occurs after reset is released.
REQ-034 The first transfer is accepted on the first rising edge after reset deasserts.

Verification
REQ-035 ADD op 000100, rdst1=5, result=0x0000_1234 -> next cycle wr_en_o=1, wr_addr_o=5, wr_data_o=0x1234; R5=0x1234; retire_count=1.
REQ-036 MUL op 000111, rdst1=3, rdst2=4, result=0xABCD_1357 -> R3=0x1357 in cycle+1, R4=0xABCD in cycle+2, in_ready=0 during cycle+1; with rdst1=rdst2=3, R3 ends at 0xABCD.
REQ-037 Back-to-back ORs to registers 1, 2, 3 with results 0x1, 0x2, 0x3 and in_valid held high -> three consecutive writes, in_ready stays 1, retire_count=3.
REQ-038 STORE op 000011 and opcode 111111 -> no register change and wr_en_o=0; retire_count increments once per op.
REQ-039 rd_addr_a=7 in the same cycle R7 is written with 0x00FF -> rd_data_a=0x00FF in that cycle.
REQ-040 Reset pulsed during WR_LO of a MUL -> all registers 0, retire_count=0, no write in the following cycles; 65536 retirements -> retire_count wraps to 0.
